gray_seq_gen: RTL and testbench
===============================

// Module: gray_seq_gen
// PURPOSE
//  Sequential Gray-code source: keeps a binary up/down count and presents it as registered
//  Gray code with a valid/ready handshake. Sits directly upstream of the binary/Gray
//  converter stage; its Dout drives that stage's Din (gray_n=1) for Gray->binary decoding.
//  Gives the converter a glitch-free, single-bit-change stream with backpressure and a wrap flag.
// PARAMETERS
//  WIDTH   4   code width in bits (>=2); count range 0 .. 2**WIDTH-1
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  EN        in   1      run request; 0 = stop issuing new words once current one is consumed
//  up_dn     in   1      1 = count up, 0 = count down; sampled at each handshake
//  load      in   1      synchronous load strobe
//  load_val  in   WIDTH  Gray-coded load value
//  ready     in   1      downstream accepts Dout this cycle
//  Dout      out  WIDTH  Gray code of internal count, registered
//  valid     out  1      Dout holds a word not yet accepted
//  wrap      out  1      1-cycle pulse: presented word resulted from a wrap-around
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset (rst=1, async): bin=0, Dout=0, valid=0, wrap=0, state=IDLE. Registers hold until
//   the first rising clk edge after rst deasserts.
//  State: bin[WIDTH-1:0] binary count. Dout is always registered as bin^(bin>>1), never
//   combinational from bin.
//  FSM states IDLE (valid=0) and RUN (valid=1).
//   IDLE: EN=1 -> RUN next edge; valid=1; Dout = gray(bin), no advance. EN=0 -> stay.
//   RUN, handshake (valid&ready): bin <= bin+1 (up_dn=1) or bin-1 (up_dn=0), mod 2**WIDTH;
//    Dout <= gray(new bin). If EN=1 stay RUN, valid stays 1 (1 word/cycle throughput).
//    If EN=0 go IDLE, valid=0; the advanced value is presented on the next EN.
//   RUN, no handshake (ready=0): Dout, valid, bin held stable; EN/up_dn changes ignored.
//  Latency: EN rise -> valid after 1 edge; handshake -> next word after 1 edge.
//  wrap: 1 for exactly the cycle that presents a word reached by up 2**WIDTH-1 -> 0 or
//   down 0 -> 2**WIDTH-1; 0 otherwise. It persists with that word while ready=0.
//  load: highest priority below rst; overrides a concurrent handshake.
//   Next edge: bin <= Gray->binary(load_val), i.e. bin[W-1]=load_val[W-1],
//   bin[i]=bin[i+1]^load_val[i] for i from W-2 down to 0; Dout <= load_val; valid=0;
//   wrap=0; state=IDLE. The pending word is discarded.
//  rst mid-stream: immediate return to reset values; any pending word is lost.
//  Invariant: consecutive accepted words differ in exactly one bit.
// TESTING (WIDTH=4)
//  1. rst pulse mid-RUN (Dout=0110) -> Dout=0000, valid=0, wrap=0 with no clock edge needed.
//  2. Reset, EN=1, up_dn=1, ready=1 for 17 cycles -> Dout 0000,0001,0011,0010,0110,...,
//     1000, then 0000 with wrap=1 for that single cycle only.
//  3. Backpressure: ready=0 for 3 cycles while Dout=0011 -> Dout=0011, valid=1 held;
//     ready=1 -> next Dout=0010.
//  4. Down count from reset: EN=1, up_dn=0, ready=1 -> 0000, then 1000 with wrap=1,
//     then 1001.
//  5. load=1, load_val=1100 during RUN -> Dout=1100, valid=0, IDLE. EN=1 -> valid=1,
//     Dout=1100; next handshake (up) -> Dout=1101.
//  6. EN dropped on a handshake at Dout=0010 -> valid=0. EN=1 later -> Dout=0110
//     (advanced word), no duplicate.

Source files
------------

// File: rtl/gray_seq_gen.sv
// Gray-code word source: a binary up/down counter presented as registered Gray code
// over a valid/ready handshake, with a load path and a wrap-around marker.
module gray_seq_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ready,
  output logic [WIDTH-1:0] Dout,
  output logic             valid,
  output logic             wrap
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO  = '0;
  localparam logic [WIDTH-1:0] ALL_1 = '1;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_t           state_p0, state_nx;
  logic [WIDTH-1:0] bin_p0, bin_nx;
  logic [WIDTH-1:0] dout_p0, dout_nx;
  logic             wrap_p0, wrap_nx;
  // wrap of an advanced word that was parked in IDLE, shown once it is presented
  logic             pend_p0, pend_nx;

  logic [WIDTH-1:0] bin_adv;
  logic             adv_wrap;

  always_comb begin
    bin_adv  = up_dn ? (bin_p0 + ONE) : (bin_p0 - ONE);
    adv_wrap = up_dn ? (bin_p0 == ALL_1) : (bin_p0 == ZERO);
  end

  always_comb begin
    state_nx = state_p0;
    bin_nx   = bin_p0;
    dout_nx  = dout_p0;
    wrap_nx  = wrap_p0;
    pend_nx  = pend_p0;
    if (load) begin
      bin_nx   = gray2bin(load_val);
      dout_nx  = load_val;
      wrap_nx  = 1'b0;
      pend_nx  = 1'b0;
      state_nx = IDLE;
    end else begin
      case (state_p0)
        IDLE: begin
          if (EN) begin
            state_nx = RUN;
            dout_nx  = bin2gray(bin_p0);
            wrap_nx  = pend_p0;
            pend_nx  = 1'b0;
          end
        end
        RUN: begin
          // Without a handshake everything holds, so EN/up_dn changes have no effect
          if (ready) begin
            bin_nx  = bin_adv;
            dout_nx = bin2gray(bin_adv);
            if (EN) begin
              wrap_nx = adv_wrap;
            end else begin
              state_nx = IDLE;
              wrap_nx  = 1'b0;
              pend_nx  = adv_wrap;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Stage p0: state, count and presented word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= IDLE;
      bin_p0   <= '0;
      dout_p0  <= '0;
      wrap_p0  <= 1'b0;
      pend_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nx;
      bin_p0   <= bin_nx;
      dout_p0  <= dout_nx;
      wrap_p0  <= wrap_nx;
      pend_p0  <= pend_nx;
    end
  end

  assign Dout  = dout_p0;
  assign valid = (state_p0 == RUN);
  assign wrap  = wrap_p0;

endmodule

// File: tb/tb_gray_seq_gen.sv
// Directed bench for gray_seq_gen at WIDTH=4: reset, up/down counting, wrap,
// backpressure, EN drop and load.
module tb_gray_seq_gen;

  logic       clk = 1'b0;
  logic       rst, EN, up_dn, load, ready;
  logic [3:0] load_val;
  logic [3:0] Dout;
  logic       valid, wrap;

  int checks = 0;
  int errors = 0;

  logic [3:0] gseq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                            4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_seq_gen #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .EN(EN), .up_dn(up_dn), .load(load),
    .load_val(load_val), .ready(ready), .Dout(Dout), .valid(valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk_word(input string tag, input logic [3:0] d, input logic v, input logic w);
    chk({tag, ".Dout"}, Dout, d);
    chk({tag, ".valid"}, {3'b0, valid}, {3'b0, v});
    chk({tag, ".wrap"}, {3'b0, wrap}, {3'b0, w});
  endtask

  initial begin
    rst = 1'b1; EN = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'b0000; ready = 1'b0;
    #3;
    chk_word("reset", 4'b0000, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk_word("idle_en0", 4'b0000, 1'b0, 1'b0);

    // Up count through a full wrap
    EN = 1'b1; up_dn = 1'b1; ready = 1'b1;
    tick();
    chk_word("up0", 4'b0000, 1'b1, 1'b0);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk_word($sformatf("up%0d", k), gseq[k], 1'b1, 1'b0);
    end
    tick();
    chk_word("up_wrap", 4'b0000, 1'b1, 1'b1);
    tick();
    chk_word("up_after_wrap", 4'b0001, 1'b1, 1'b0);
    tick();
    chk_word("up_0011", 4'b0011, 1'b1, 1'b0);

    // Backpressure at 0011; up_dn/EN wiggles must be ignored
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      up_dn = k[0];
      EN    = ~k[0];
      tick();
      chk_word($sformatf("hold%0d", k), 4'b0011, 1'b1, 1'b0);
    end
    up_dn = 1'b1; EN = 1'b1; ready = 1'b1;
    tick();
    chk_word("release", 4'b0010, 1'b1, 1'b0);

    // EN dropped on the handshake of 0010
    EN = 1'b0;
    tick();
    chk_word("en_drop", 4'b0110, 1'b0, 1'b0);
    tick();
    chk_word("en_drop_idle", 4'b0110, 1'b0, 1'b0);
    EN = 1'b1;
    tick();
    chk_word("en_resume", 4'b0110, 1'b1, 1'b0);
    tick();
    chk_word("resume_next", 4'b0111, 1'b1, 1'b0);

    // Load during RUN overrides the concurrent handshake
    load = 1'b1; load_val = 4'b1100; EN = 1'b0;
    tick();
    chk_word("load", 4'b1100, 1'b0, 1'b0);
    load = 1'b0;
    tick();
    chk_word("load_idle", 4'b1100, 1'b0, 1'b0);
    EN = 1'b1;
    tick();
    chk_word("load_present", 4'b1100, 1'b1, 1'b0);
    tick();
    chk_word("load_next", 4'b1101, 1'b1, 1'b0);

    // Asynchronous reset mid-RUN, observed between clock edges
    #2 rst = 1'b1;
    up_dn = 1'b0;
    #1;
    chk_word("async_rst", 4'b0000, 1'b0, 1'b0);
    #1 rst = 1'b0;

    // Down count from reset: wraps 0 -> 15
    tick();
    chk_word("dn0", 4'b0000, 1'b1, 1'b0);
    tick();
    chk_word("dn_wrap", 4'b1000, 1'b1, 1'b1);
    tick();
    chk_word("dn_next", 4'b1001, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
